// File: rtl/seq_alu_pkg.sv
// seq_alu_pkg: opcode, error-code and FSM state constants shared by the
// sequential ALU and its divider core.
package seq_alu_pkg;

  // Opcodes; 5..15 are invalid
  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_MUL = 4'd2;
  localparam logic [3:0] OP_DIV = 4'd3;
  localparam logic [3:0] OP_MOD = 4'd4;

  // Error codes reported alongside the result
  localparam logic [1:0] ERR_OK   = 2'b00;
  localparam logic [1:0] ERR_OVF  = 2'b01;
  localparam logic [1:0] ERR_DIV0 = 2'b10;
  localparam logic [1:0] ERR_INV  = 2'b11;

  // FSM states
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

endpackage

// File: rtl/seq_udiv_core.sv
// seq_udiv_core: unsigned restoring divider, one quotient bit per step.
// Ports:
//   clk, rst    clock, synchronous active-high reset
//   load        capture dividend/divisor, clear step counter
//   step        perform one restoring iteration
//   dividend    WIDTH-bit unsigned dividend
//   divisor     WIDTH-bit unsigned divisor (nonzero when stepped)
//   step_cnt    number of steps done since load
//   quotient    quotient, valid after WIDTH steps
//   remainder   remainder, valid after WIDTH steps
module seq_udiv_core #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CW    = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             step,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [CW-1:0]    step_cnt,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] dvsr_q, dvsr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH:0]   rem_sh_c;
  logic [WIDTH:0]   diff_c;

  // Partial remainder shifted left with the next dividend bit; trial subtract.
  // rem_sh < 2*divisor, so bit WIDTH of the difference is a valid sign.
  assign rem_sh_c = {rem_q, quo_q[WIDTH-1]};
  assign diff_c   = rem_sh_c - {1'b0, dvsr_q};

  always_comb begin
    quo_d  = quo_q;
    rem_d  = rem_q;
    dvsr_d = dvsr_q;
    cnt_d  = cnt_q;
    if (load) begin
      quo_d  = dividend;
      rem_d  = '0;
      dvsr_d = divisor;
      cnt_d  = '0;
    end else if (step) begin
      cnt_d = cnt_q + CW'(1);
      if (!diff_c[WIDTH]) begin
        rem_d = diff_c[WIDTH-1:0];
        quo_d = {quo_q[WIDTH-2:0], 1'b1};
      end else begin
        rem_d = rem_sh_c[WIDTH-1:0];
        quo_d = {quo_q[WIDTH-2:0], 1'b0};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      quo_q  <= '0;
      rem_q  <= '0;
      dvsr_q <= '0;
      cnt_q  <= '0;
    end else begin
      quo_q  <= quo_d;
      rem_q  <= rem_d;
      dvsr_q <= dvsr_d;
      cnt_q  <= cnt_d;
    end
  end

  assign step_cnt  = cnt_q;
  assign quotient  = quo_q;
  assign remainder = rem_q;

endmodule

// File: rtl/seq_alu.sv
// seq_alu: multi-cycle signed ALU (add, sub, mul, div, mod) with a
// start/busy/done handshake. Mul is inline shift-add; div/mod use seq_udiv_core.
// Ports:
//   clk, rst   clock, synchronous active-high reset
//   start      request, accepted when idle or in the done cycle
//   op_code    0 add, 1 sub, 2 mul, 3 div, 4 mod, others invalid
//   input1/2   signed operands, sampled at accept
//   busy       operation in progress (CALC/FIX)
//   done       one-cycle pulse, output1/err_code updated
//   output1    2*WIDTH signed result, held until next done
//   err_code   00 ok, 01 overflow, 10 divide-by-zero, 11 invalid
module seq_alu
  import seq_alu_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [3:0]         op_code,
  input  logic [WIDTH-1:0]   input1,
  input  logic [WIDTH-1:0]   input2,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] output1,
  output logic [1:0]         err_code
);

  localparam int unsigned CW = $clog2(WIDTH);
  localparam int unsigned RW = 2 * WIDTH;

  logic [1:0]       state_q, state_d;
  logic [3:0]       op_q, op_d;
  logic             neg_q, neg_d;
  logic             a_neg_q, a_neg_d;
  logic [RW-1:0]    acc_q, acc_d;
  logic [RW-1:0]    mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [RW-1:0]    out_q, out_d;
  logic [1:0]       err_q, err_d;

  logic             accept_c;
  logic             div_load_c;
  logic             div_step_c;
  logic [WIDTH-1:0] a_mag_c;
  logic [WIDTH-1:0] b_mag_c;
  logic [WIDTH:0]   sum_c;
  logic [WIDTH:0]   dif_c;
  logic [CW-1:0]    step_cnt;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] rem;
  logic [RW-1:0]    quo_ext_c;
  logic [RW-1:0]    rem_ext_c;

  // Magnitudes read as unsigned: |-2^(WIDTH-1)| = 2^(WIDTH-1) fits without wrap
  assign a_mag_c = input1[WIDTH-1] ? -input1 : input1;
  assign b_mag_c = input2[WIDTH-1] ? -input2 : input2;

  // One extra bit keeps add/sub exact; overflow when the top two bits differ
  assign sum_c = {input1[WIDTH-1], input1} + {input2[WIDTH-1], input2};
  assign dif_c = {input1[WIDTH-1], input1} - {input2[WIDTH-1], input2};

  assign quo_ext_c = {{WIDTH{1'b0}}, quo};
  assign rem_ext_c = {{WIDTH{1'b0}}, rem};

  assign accept_c = start && (state_q == S_IDLE || state_q == S_DONE);

  seq_udiv_core #(.WIDTH(WIDTH), .CW(CW)) u_div (
    .clk       (clk),
    .rst       (rst),
    .load      (div_load_c),
    .step      (div_step_c),
    .dividend  (a_mag_c),
    .divisor   (b_mag_c),
    .step_cnt  (step_cnt),
    .quotient  (quo),
    .remainder (rem)
  );

  // Next-state, datapath and output logic
  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    neg_d      = neg_q;
    a_neg_d    = a_neg_q;
    acc_d      = acc_q;
    mcand_d    = mcand_q;
    mplier_d   = mplier_q;
    out_d      = out_q;
    err_d      = err_q;
    div_load_c = 1'b0;
    div_step_c = 1'b0;

    case (state_q)
      S_IDLE, S_DONE: begin
        state_d = S_IDLE;
        if (accept_c) begin
          op_d    = op_code;
          neg_d   = input1[WIDTH-1] ^ input2[WIDTH-1];
          a_neg_d = input1[WIDTH-1];
          case (op_code)
            OP_ADD: begin
              out_d   = {{(WIDTH-1){sum_c[WIDTH]}}, sum_c};
              err_d   = (sum_c[WIDTH] != sum_c[WIDTH-1]) ? ERR_OVF : ERR_OK;
              state_d = S_DONE;
            end
            OP_SUB: begin
              out_d   = {{(WIDTH-1){dif_c[WIDTH]}}, dif_c};
              err_d   = (dif_c[WIDTH] != dif_c[WIDTH-1]) ? ERR_OVF : ERR_OK;
              state_d = S_DONE;
            end
            OP_MUL: begin
              // Divider load also clears the shared step counter
              div_load_c = 1'b1;
              acc_d      = '0;
              mcand_d    = {{WIDTH{1'b0}}, a_mag_c};
              mplier_d   = b_mag_c;
              state_d    = S_CALC;
            end
            OP_DIV, OP_MOD: begin
              if (input2 == '0) begin
                out_d   = '0;
                err_d   = ERR_DIV0;
                state_d = S_DONE;
              end else begin
                div_load_c = 1'b1;
                state_d    = S_CALC;
              end
            end
            default: begin
              out_d   = '0;
              err_d   = ERR_INV;
              state_d = S_DONE;
            end
          endcase
        end
      end

      S_CALC: begin
        // One multiplier bit and one divider bit per cycle, WIDTH cycles
        div_step_c = 1'b1;
        if (mplier_q[0]) begin
          acc_d = acc_q + mcand_q;
        end
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        if (step_cnt == CW'(WIDTH - 1)) begin
          state_d = S_FIX;
        end
      end

      S_FIX: begin
        // Apply result signs to the unsigned magnitudes
        state_d = S_DONE;
        err_d   = ERR_OK;
        case (op_q)
          OP_MUL: out_d = neg_q ? -acc_q : acc_q;
          OP_DIV: begin
            out_d = neg_q ? -quo_ext_c : quo_ext_c;
            // A positive quotient of 2^(WIDTH-1) only arises from MIN / -1
            if (!neg_q && quo[WIDTH-1]) begin
              err_d = ERR_OVF;
            end
          end
          OP_MOD: out_d = a_neg_q ? -rem_ext_c : rem_ext_c;
          default: out_d = '0;
        endcase
      end

      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d == S_CALC) || (state_d == S_FIX);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      op_q     <= '0;
      neg_q    <= 1'b0;
      a_neg_q  <= 1'b0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      out_q    <= '0;
      err_q    <= ERR_OK;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      neg_q    <= neg_d;
      a_neg_q  <= a_neg_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      out_q    <= out_d;
      err_q    <= err_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign output1  = out_q;
  assign err_code = err_q;

endmodule

// File: tb/tb_seq_alu.sv
// tb_seq_alu: directed and random stimulus for seq_alu, checked against an
// arithmetic reference model (signed integer math on longint).
module tb_seq_alu;

  localparam int unsigned W = 16;

  logic           clk = 1'b0;
  logic           rst;
  logic           start;
  logic [3:0]     op_code;
  logic [W-1:0]   input1;
  logic [W-1:0]   input2;
  logic           busy;
  logic           done;
  logic [2*W-1:0] output1;
  logic [1:0]     err_code;

  int n_asserts = 0;
  int n_fail    = 0;

  always #5 clk = ~clk;

  seq_alu #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .op_code  (op_code),
    .input1   (input1),
    .input2   (input2),
    .busy     (busy),
    .done     (done),
    .output1  (output1),
    .err_code (err_code)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: exact signed arithmetic, C-style truncating div/mod
  task automatic model(input logic [3:0] op, input logic signed [W-1:0] a,
                       input logic signed [W-1:0] b, output logic [2*W-1:0] o,
                       output logic [1:0] e, output int lat);
    longint sa, sb, r, lim;
    sa  = a;
    sb  = b;
    lim = longint'(1) <<< (W - 1);
    r   = 0;
    e   = 2'd0;
    lat = 1;
    case (op)
      4'd0: begin r = sa + sb; e = (r >= lim || r < -lim) ? 2'd1 : 2'd0; end
      4'd1: begin r = sa - sb; e = (r >= lim || r < -lim) ? 2'd1 : 2'd0; end
      4'd2: begin r = sa * sb; lat = W + 2; end
      4'd3, 4'd4: begin
        if (sb == 0) begin
          e = 2'd2;
        end else begin
          lat = W + 2;
          if (op == 4'd3) begin
            r = sa / sb;
            e = (r >= lim) ? 2'd1 : 2'd0;
          end else begin
            r = sa % sb;
          end
        end
      end
      default: e = 2'd3;
    endcase
    o = r[2*W-1:0];
  endtask

  // Issue one op (optionally in the current DONE cycle) and check its result
  task automatic run_op(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input bit b2b, input bit poke_busy,
                        output logic [2*W-1:0] eo, output logic [1:0] ee);
    int el;
    int cyc;
    model(op, a, b, eo, ee, el);
    if (!b2b) @(negedge clk);
    start   = 1'b1;
    op_code = op;
    input1  = a;
    input2  = b;
    @(negedge clk);
    start   = 1'b0;
    op_code = 4'($urandom);
    input1  = W'($urandom);
    input2  = W'($urandom);
    cyc     = 1;
    check("busy_c1", 64'(busy), 64'(el > 1));
    while (!done && cyc < 4 * W) begin
      start = (poke_busy && cyc == 3);
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    check("done", 64'(done), 64'd1);
    check("latency", 64'(cyc), 64'(el));
    check("output1", 64'(output1), 64'(eo));
    check("err_code", 64'(err_code), 64'(ee));
  endtask

  // Cycle after done: pulse dropped, result held, nothing queued
  task automatic hold_check(input logic [2*W-1:0] eo, input logic [1:0] ee);
    @(negedge clk);
    check("hold_done", 64'(done), 64'd0);
    check("hold_busy", 64'(busy), 64'd0);
    check("hold_out", 64'(output1), 64'(eo));
    check("hold_err", 64'(err_code), 64'(ee));
  endtask

  initial begin
    logic [2*W-1:0] eo;
    logic [1:0]     ee;
    bit             saw_done;
    bit             b2b;
    logic [3:0]     rop;
    logic [W-1:0]   ra, rb;

    // Reset asserted together with start: reset wins
    rst     = 1'b1;
    start   = 1'b1;
    op_code = 4'd0;
    input1  = 16'd1;
    input2  = 16'd2;
    repeat (2) @(negedge clk);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_out", 64'(output1), 64'd0);
    check("rst_err", 64'(err_code), 64'd0);
    rst   = 1'b0;
    start = 1'b0;
    @(negedge clk);
    check("post_rst_done", 64'(done), 64'd0);

    // Directed cases
    run_op(4'd0, 16'd11, 16'd15, 1'b0, 1'b0, eo, ee);
    check("add_exact", 64'(output1), 64'd26);
    hold_check(eo, ee);
    run_op(4'd0, 16'd32000, 16'd16000, 1'b0, 1'b0, eo, ee);
    check("add_ovf", 64'(err_code), 64'd1);
    run_op(4'd1, 16'h8000, 16'd1, 1'b0, 1'b0, eo, ee);
    run_op(4'd2, 16'd32000, 16'd16000, 1'b0, 1'b0, eo, ee);
    check("mul_big", 64'(output1), 64'd512000000);
    run_op(4'd2, -16'sd3, 16'd5, 1'b0, 1'b0, eo, ee);
    run_op(4'd2, 16'h8000, 16'h8000, 1'b0, 1'b0, eo, ee);
    run_op(4'd3, -16'sd7, 16'd2, 1'b0, 1'b0, eo, ee);
    run_op(4'd4, -16'sd7, 16'd2, 1'b0, 1'b0, eo, ee);
    run_op(4'd3, 16'd32000, 16'd16000, 1'b0, 1'b0, eo, ee);
    run_op(4'd4, 16'd32000, 16'd16000, 1'b0, 1'b0, eo, ee);
    run_op(4'd3, 16'h8000, 16'hFFFF, 1'b0, 1'b0, eo, ee);
    check("div_min_ovf", 64'(output1), 64'd32768);
    run_op(4'd4, 16'h8000, 16'hFFFF, 1'b0, 1'b0, eo, ee);
    run_op(4'd3, 16'd11, 16'd0, 1'b0, 1'b0, eo, ee);
    run_op(4'd4, 16'd11, 16'd0, 1'b0, 1'b0, eo, ee);
    run_op(4'd9, 16'd11, 16'd3, 1'b0, 1'b0, eo, ee);

    // Start while busy is ignored; then back-to-back from the DONE cycle
    run_op(4'd2, -16'sd123, 16'd77, 1'b0, 1'b1, eo, ee);
    hold_check(eo, ee);
    run_op(4'd3, 16'd1000, -16'sd7, 1'b0, 1'b0, eo, ee);
    run_op(4'd0, 16'd5, 16'd6, 1'b1, 1'b0, eo, ee);
    run_op(4'd4, 16'd1000, -16'sd7, 1'b1, 1'b0, eo, ee);
    hold_check(eo, ee);

    // Reset in the middle of a divide
    @(negedge clk);
    start   = 1'b1;
    op_code = 4'd3;
    input1  = -16'sd7;
    input2  = 16'd2;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_done", 64'(done), 64'd0);
    check("midrst_out", 64'(output1), 64'd0);
    check("midrst_err", 64'(err_code), 64'd0);
    saw_done = 1'b0;
    repeat (W + 4) begin
      @(negedge clk);
      if (done) saw_done = 1'b1;
    end
    check("midrst_no_done", 64'(saw_done), 64'd0);

    // Random operations, mixing idle gaps and back-to-back issue
    b2b = 1'b0;
    for (int i = 0; i < 60; i++) begin
      rop = 4'($urandom_range(0, 6));
      ra  = W'($urandom);
      rb  = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom);
      if ($urandom_range(0, 9) == 0) begin
        ra = 16'h8000;
        rb = 16'hFFFF;
      end
      run_op(rop, ra, rb, b2b, 1'($urandom_range(0, 1)), eo, ee);
      b2b = 1'($urandom_range(0, 1));
      if (!b2b) hold_check(eo, ee);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
